// File: rtl/neopixel_pkg.sv
// Shared types and constants for the NeoPixel frame path.
// Pixels are GRB with green in the top byte.
package neopixel_pkg;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    LATCH = 2'd3
  } sched_state_t;

  localparam int WS2812_LATCH_US = 50;
  localparam int CORE_CLK_MHZ    = 100;

  // Pixel index width; a single-pixel chain still needs one address bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neopixel_pixel_buffer.sv
// Double-banked pixel store: writes land in the back bank, reads come combinationally
// from the front bank; swap exchanges the two roles on the next clock.
module neopixel_pixel_buffer
  import neopixel_pkg::*;
#(
  parameter int NUM_PIXELS = 3,
  parameter int IDX_W      = idx_w(NUM_PIXELS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             swap,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  pixel_t           wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output pixel_t           rd_data,
  output logic             rd_bank
);

  pixel_t bank [2][NUM_PIXELS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_bank <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int p = 0; p < NUM_PIXELS; p++) begin
          bank[b][p] <= '0;
        end
      end
    end else begin
      if (swap) begin
        rd_bank <= ~rd_bank;
      end
      // Addresses past the end of the chain are silently dropped.
      if (wr_en && (int'(wr_addr) < NUM_PIXELS)) begin
        bank[~rd_bank][wr_addr] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_idx) < NUM_PIXELS) begin
      rd_data = bank[rd_bank][rd_idx];
    end
  end

endmodule

// File: rtl/neopixel_frame_scheduler.sv
// Streams double-buffered frames to the serializer one pixel per accepted handshake,
// then waits for serializer idle and a fixed latch gap before the next frame may start.
module neopixel_frame_scheduler
  import neopixel_pkg::*;
#(
  parameter int NUM_PIXELS   = 3,
  parameter int LATCH_CYCLES = WS2812_LATCH_US * CORE_CLK_MHZ
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [idx_w(NUM_PIXELS)-1:0] wr_addr,
  input  logic [23:0]                  wr_data,
  input  logic                         frame_valid,
  output logic                         px_valid,
  output logic [23:0]                  px_data,
  input  logic                         px_ready,
  input  logic                         ser_idle,
  output logic                         flushing,
  output logic                         frame_drop
);

  localparam int IDX_W = idx_w(NUM_PIXELS);
  localparam int CNT_W = $clog2(LATCH_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATCH_CYCLES - 1);

  sched_state_t     state, state_nxt;
  logic             pending, pending_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             swap;
  logic             rd_bank;
  pixel_t           front_px;

  neopixel_pixel_buffer #(
    .NUM_PIXELS (NUM_PIXELS),
    .IDX_W      (IDX_W)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .swap    (swap),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_idx  (idx),
    .rd_data (front_px),
    .rd_bank (rd_bank)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pending    <= 1'b0;
      idx        <= '0;
      cnt        <= '0;
      flushing   <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      flushing   <= (state_nxt != IDLE);
      // A second frame while one is already queued is lost; the queued one is kept.
      frame_drop <= frame_valid && pending;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    swap        = 1'b0;

    if (frame_valid && !pending) begin
      pending_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (pending) begin
          swap        = 1'b1;
          pending_nxt = 1'b0;
          idx_nxt     = '0;
          state_nxt   = SEND;
        end
      end
      SEND: begin
        if (px_ready) begin
          if (idx == IDX_LAST) begin
            state_nxt = DRAIN;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (ser_idle) begin
          cnt_nxt   = '0;
          state_nxt = LATCH;
        end
      end
      LATCH: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    px_valid = (state == SEND);
    px_data  = px_valid ? front_px : 24'h0;
  end

endmodule
